// File: rtl/tx_arbiter_pkg.sv
// Purpose: shared item width and helpers for the tx arbiter slice.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
`ifndef PAYLOAD_SIZE
`include "constants.v"
`endif

package tx_arbiter_pkg;

  // One queued item: payload plus destination address.
  localparam int W = `PAYLOAD_SIZE + `ADDR_BITS;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/constants.v
// Shared payload/address width constants for the tx datapath.
// Included once per compilation unit; guarded against repeat inclusion.
// No logic here, definitions only.
`ifndef CONSTANTS_V
`define CONSTANTS_V
`define PAYLOAD_SIZE 8
`define ADDR_BITS 4
`endif

// File: rtl/tx_arbiter_rr_pick.sv
// Purpose: combinational round-robin winner search over a request vector.
// Latency: zero (pure combinational).
// Backpressure: none; caller decides whether to use the winner.
// Ports: req (requests), last_grant (previous winner) ->
//        winner_oh (one-hot), winner_idx (index), any (some request set).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDW-1:0]     winner_idx,
  output logic               any
);

  always_comb begin
    int idx;
    idx        = 0;
    winner_oh  = '0;
    winner_idx = '0;
    any        = 1'b0;
    // Scan starting just after the previous winner so it ends up last.
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(last_grant) + 1 + off) % NUM_REQ;
      if (!any && req[idx]) begin
        any            = 1'b1;
        winner_oh[idx] = 1'b1;
        winner_idx     = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Purpose: round-robin arbiter feeding one tx serial channel from NUM_REQ requesters.
// Latency: grant visible one edge after req_in is sampled in IDLE; ack/tx_req last one cycle.
// Backpressure: no grant while tx_busy; tx_req re-pulsed if tx_busy never rises.
// Ports: clk/reset (sync, active-high); req_in/data_in from requesters; ack back to them;
//        tx_req/tx_data/tx_busy to the tx block; grant_id/active status.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 8,
  localparam int IDW          = idx_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_in,
  input  logic [NUM_REQ*W-1:0] data_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_req,
  output logic [W-1:0]         tx_data,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 active
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } state_e;

  localparam int CW = $clog2(START_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_req_q, tx_req_d;
  logic [W-1:0]       tx_data_q, tx_data_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               retry_seen_q, retry_seen_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req        (req_in),
    .last_grant (last_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    tx_req_d     = 1'b0;
    tx_data_d    = tx_data_q;
    grant_id_d   = grant_id_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    retry_seen_d = retry_seen_q;
    case (state_q)
      IDLE: begin
        if (!tx_busy && pick_any) begin
          ack_d      = pick_oh;
          tx_req_d   = 1'b1;
          tx_data_d  = data_in[int'(pick_idx)*W +: W];
          grant_id_d = pick_idx;
          last_d     = pick_idx;
          cnt_d      = '0;
          state_d    = WAIT_START;
        end
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          // tx block missed the start pulse: poke it again, item already acked.
          tx_req_d     = 1'b1;
          cnt_d        = '0;
          retry_seen_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ack_q        <= '0;
      tx_req_q     <= 1'b0;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      // Pointing at the top index makes the first search begin at 0.
      last_q       <= IDW'(NUM_REQ - 1);
      cnt_q        <= '0;
      active_q     <= 1'b0;
      retry_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      retry_seen_q <= retry_seen_d;
    end
  end

  assign ack      = ack_q;
  assign tx_req   = tx_req_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign active   = active_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Purpose: directed self-checking bench for tx_arbiter with NUM_REQ=4.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: tx_busy driven by the bench to model the tx block.
module tb_tx_arbiter;
  import tx_arbiter_pkg::*;

  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_in;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   ack;
  logic           tx_req;
  logic [W-1:0]   tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] item [N];

  tx_arbiter #(
    .NUM_REQ       (N),
    .START_TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_in   (req_in),
    .data_in  (data_in),
    .ack      (ack),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .active   (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int exp_order [5];
    logic got;
    int pulses;

    item[0] = 12'h001;
    item[1] = 12'h2B1;
    item[2] = 12'h3C2;
    item[3] = 12'h4D3;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = item[i];
    reset   = 1'b1;
    req_in  = '0;
    tx_busy = 1'b0;
    do_reset();

    // Reset state.
    check("rst_ack", ack, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_active", active, 0);

    // Single request, busy 2 cycles after the grant, then released.
    req_in = 4'b0001;
    tick();
    check("single_ack", ack, 4'b0001);
    check("single_tx_req", tx_req, 1);
    check("single_tx_data", tx_data, 12'h001);
    check("single_grant_id", grant_id, 0);
    check("single_active", active, 1);
    req_in = '0;
    tick();
    check("single_ack_drop", ack, 0);
    check("single_tx_req_drop", tx_req, 0);
    tx_busy = 1'b1;
    tick();
    tick();
    check("single_active_busy", active, 1);
    tx_busy = 1'b0;
    tick();
    check("single_active_fall", active, 0);
    check("single_data_hold", tx_data, 12'h001);

    // Contention: all four hold requests, tx busy 5 cycles per item.
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    req_in = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        tick();
        if (ack != 0) got = 1'b1;
      end
      check("cont_ack_seen", got, 1);
      check("cont_ack", ack, 1 << exp_order[k]);
      check("cont_grant_id", grant_id, exp_order[k]);
      check("cont_tx_data", tx_data, item[exp_order[k]]);
      check("cont_tx_req", tx_req, 1);
      if (k == 4) req_in = '0;
      tx_busy = 1'b1;
      repeat (5) tick();
      tx_busy = 1'b0;
    end
    tick();
    check("cont_idle", active, 0);

    // Busy channel in IDLE: no grant until tx_busy falls.
    tx_busy = 1'b1;
    req_in  = 4'b0010;
    for (int t = 0; t < 3; t++) begin
      tick();
      check("busy_no_ack", ack, 0);
    end
    tx_busy = 1'b0;
    tick();
    check("busy_ack", ack, 4'b0010);
    check("busy_grant_id", grant_id, 1);
    req_in  = '0;
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tick();
    check("busy_idle", active, 0);

    // Start timeout: tx_busy never rises, tx_req repeats every 8 cycles.
    req_in = 4'b0100;
    tick();
    check("to_ack", ack, 4'b0100);
    check("to_tx_req", tx_req, 1);
    req_in = '0;
    pulses = 0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (ack != 0) pulses++;
      check("to_tx_req_pattern", tx_req, (c == 8 || c == 16) ? 1 : 0);
    end
    check("to_ack_once", pulses, 0);
    check("to_active", active, 1);

    // Reset in WAIT_DONE: last owner was 2, so without reset 1001 would pick 3.
    tx_busy = 1'b1;
    tick();
    check("rmid_wait_done", active, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_ack", ack, 0);
    check("rmid_tx_req", tx_req, 0);
    check("rmid_tx_data", tx_data, 0);
    check("rmid_grant_id", grant_id, 0);
    check("rmid_active", active, 0);
    tx_busy = 1'b0;
    req_in  = 4'b1001;
    tick();
    check("rmid_ack_next", ack, 4'b0001);
    check("rmid_grant_next", grant_id, 0);
    req_in  = '0;
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tick();

    // Withdrawal: requester 2 asks only while the channel is busy.
    tx_busy = 1'b1;
    req_in  = 4'b0100;
    tick();
    tick();
    req_in = '0;
    tick();
    tx_busy = 1'b0;
    pulses = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (ack != 0) pulses++;
    end
    check("wd_never_acked", pulses, 0);
    req_in = 4'b1000;
    tick();
    check("wd_next_ack", ack, 4'b1000);
    check("wd_next_grant", grant_id, 3);
    req_in = '0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
